// File: rtl/pe_mac_sequencer.sv
// Operand sequencer for the PE MAC: issues one (act, weight, psum) triple per cycle for a
// stride-1 1-D row convolution and writes finished psums back into the psum spad.
//   state   | meaning
//   S_IDLE  | waiting for start; spads writable
//   S_RUN   | one MAC issue per cycle
//   S_DRAIN | last psum writeback
//   S_DONE  | one-cycle done pulse
module pe_mac_sequencer #(
  parameter int IN_BITWIDTH  = 16,
  parameter int OUT_BITWIDTH = 32,
  parameter int ACT_DEPTH    = 16,
  parameter int FILT_DEPTH   = 8,
  parameter int PSUM_DEPTH   = 16
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_act_wr_en,
  input  logic [$clog2(ACT_DEPTH)-1:0]    i_act_wr_addr,
  input  logic [IN_BITWIDTH-1:0]          i_act_wr_data,
  input  logic                            i_filt_wr_en,
  input  logic [$clog2(FILT_DEPTH)-1:0]   i_filt_wr_addr,
  input  logic [IN_BITWIDTH-1:0]          i_filt_wr_data,
  input  logic                            i_psum_wr_en,
  input  logic [$clog2(PSUM_DEPTH)-1:0]   i_psum_wr_addr,
  input  logic [IN_BITWIDTH-1:0]          i_psum_wr_data,
  input  logic [$clog2(PSUM_DEPTH)-1:0]   i_psum_rd_addr,
  output logic [IN_BITWIDTH-1:0]          o_psum_rd_data,
  input  logic                            i_start,
  input  logic [$clog2(FILT_DEPTH):0]     i_filt_len,
  input  logic [$clog2(PSUM_DEPTH):0]     i_num_psum,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_cfg_err,
  output logic [IN_BITWIDTH-1:0]          o_mac_a,
  output logic [IN_BITWIDTH-1:0]          o_mac_w,
  output logic [IN_BITWIDTH-1:0]          o_mac_sum,
  output logic                            o_mac_en,
  input  logic [OUT_BITWIDTH-1:0]         i_mac_out
);
  localparam int AAW = $clog2(ACT_DEPTH);
  localparam int FAW = $clog2(FILT_DEPTH);
  localparam int PAW = $clog2(PSUM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_next_state;

  logic [IN_BITWIDTH-1:0] r_act  [ACT_DEPTH];
  logic [IN_BITWIDTH-1:0] r_filt [FILT_DEPTH];
  logic [IN_BITWIDTH-1:0] r_psum [PSUM_DEPTH];

  logic [FAW:0]           r_filt_len;
  logic [PAW:0]           r_num_psum;
  logic [PAW-1:0]         r_p, r_wb_addr;
  logic [FAW-1:0]         r_k;
  logic                   r_wb_pend, r_cfg_err;
  logic [IN_BITWIDTH-1:0] r_hold_a, r_hold_w, r_hold_sum;

  int                     w_fl, w_np;
  logic                   w_cfg_ok, w_k_last, w_p_last, w_busy, w_issue;
  logic [AAW:0]           w_act_idx;
  logic [IN_BITWIDTH-1:0] w_mac_lo, w_live_a, w_live_w, w_live_sum;
  logic                   w_unused_mac_hi;

  assign w_fl     = int'(i_filt_len);
  assign w_np     = int'(i_num_psum);
  assign w_cfg_ok = (w_fl != 0) && (w_np != 0) && (w_np <= PSUM_DEPTH) &&
                    (w_fl <= FILT_DEPTH) && (w_fl + w_np - 1 <= ACT_DEPTH);
  assign w_k_last = (int'(r_k) == int'(r_filt_len) - 1);
  assign w_p_last = (int'(r_p) == int'(r_num_psum) - 1);
  assign w_act_idx = (AAW+1)'(r_p) + (AAW+1)'(r_k);
  assign w_mac_lo  = i_mac_out[IN_BITWIDTH-1:0];
  assign w_unused_mac_hi = ^i_mac_out[OUT_BITWIDTH-1:IN_BITWIDTH];
  assign o_psum_rd_data  = r_psum[i_psum_rd_addr];
  assign o_cfg_err       = r_cfg_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_start && w_cfg_ok) w_next_state = S_RUN;
      S_RUN:   if (w_k_last && w_p_last) w_next_state = S_DRAIN;
      S_DRAIN: w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy     = 1'b0;
    w_issue    = 1'b0;
    o_done     = 1'b0;
    w_live_a   = r_act[w_act_idx[AAW-1:0]];
    w_live_w   = r_filt[r_k];
    // first tap of an output seeds from the spad, later taps chain the MAC result
    w_live_sum = (r_k == '0) ? r_psum[r_p] : w_mac_lo;
    case (r_state)
      S_RUN:   begin w_busy = 1'b1; w_issue = 1'b1; end
      S_DRAIN: w_busy = 1'b1;
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
    o_busy    = w_busy;
    o_mac_en  = w_issue;
    o_mac_a   = w_issue ? w_live_a   : r_hold_a;
    o_mac_w   = w_issue ? w_live_w   : r_hold_w;
    o_mac_sum = w_issue ? w_live_sum : r_hold_sum;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_filt_len <= '0;
      r_num_psum <= '0;
      r_p        <= '0;
      r_k        <= '0;
      r_wb_pend  <= 1'b0;
      r_wb_addr  <= '0;
      r_cfg_err  <= 1'b0;
      r_hold_a   <= '0;
      r_hold_w   <= '0;
      r_hold_sum <= '0;
    end else begin
      r_cfg_err <= (r_state == S_IDLE) && i_start && !w_cfg_ok;
      r_wb_pend <= 1'b0;
      if (r_state == S_IDLE && i_start && w_cfg_ok) begin
        r_filt_len <= i_filt_len;
        r_num_psum <= i_num_psum;
        r_p        <= '0;
        r_k        <= '0;
      end
      if (w_issue) begin
        r_hold_a   <= w_live_a;
        r_hold_w   <= w_live_w;
        r_hold_sum <= w_live_sum;
        if (w_k_last) begin
          r_k       <= '0;
          r_p       <= r_p + 1'b1;
          r_wb_pend <= 1'b1;
          r_wb_addr <= r_p;
        end else begin
          r_k <= r_k + 1'b1;
        end
      end
    end
  end

  // the finished sum appears on mac_out one cycle after its last tap was issued
  always_ff @(posedge i_clk) begin
    if (!w_busy) begin
      if (i_act_wr_en)  r_act[i_act_wr_addr]   <= i_act_wr_data;
      if (i_filt_wr_en) r_filt[i_filt_wr_addr] <= i_filt_wr_data;
      if (i_psum_wr_en) r_psum[i_psum_wr_addr] <= i_psum_wr_data;
    end else if (r_wb_pend && !i_reset) begin
      r_psum[r_wb_addr] <= w_mac_lo;
    end
  end
endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Randomized bench for pe_mac_sequencer with a behavioural MAC, an arithmetic reference
// model of the spads/schedule and a per-cycle compare process.
module tb_pe_mac_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        act_wr_en, filt_wr_en, psum_wr_en, start;
  logic [3:0]  act_wr_addr, psum_wr_addr, psum_rd_addr;
  logic [2:0]  filt_wr_addr;
  logic [15:0] act_wr_data, filt_wr_data, psum_wr_data, psum_rd_data;
  logic [3:0]  filt_len;
  logic [4:0]  num_psum;
  logic        busy, done, cfg_err, mac_en;
  logic [15:0] mac_a, mac_w, mac_sum;
  logic [31:0] mac_out = '0;

  always #5 clk = ~clk;

  pe_mac_sequencer dut (
    .i_clk(clk), .i_reset(reset),
    .i_act_wr_en(act_wr_en), .i_act_wr_addr(act_wr_addr), .i_act_wr_data(act_wr_data),
    .i_filt_wr_en(filt_wr_en), .i_filt_wr_addr(filt_wr_addr), .i_filt_wr_data(filt_wr_data),
    .i_psum_wr_en(psum_wr_en), .i_psum_wr_addr(psum_wr_addr), .i_psum_wr_data(psum_wr_data),
    .i_psum_rd_addr(psum_rd_addr), .o_psum_rd_data(psum_rd_data),
    .i_start(start), .i_filt_len(filt_len), .i_num_psum(num_psum),
    .o_busy(busy), .o_done(done), .o_cfg_err(cfg_err),
    .o_mac_a(mac_a), .o_mac_w(mac_w), .o_mac_sum(mac_sum), .o_mac_en(mac_en),
    .i_mac_out(mac_out)
  );

  // behavioural MAC: registered a*w+sum
  always @(posedge clk) if (mac_en) mac_out <= {16'b0, mac_a} * {16'b0, mac_w} + {16'b0, mac_sum};

  logic [15:0] act_m [16];
  logic [15:0] filt_m [8];
  logic [15:0] psum_m [16];
  bit          in_job = 0, exp_cfg_err = 0, valid = 0;
  int          jc = 0, fl = 1, np = 1;
  logic [15:0] last_a = '0, last_w = '0, last_sum = '0;
  int          vecs = 0, errs = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // psum[p] seed plus the first k taps, modulo 2^16
  function automatic logic [15:0] partial(int p, int k);
    logic [31:0] s;
    s = {16'b0, psum_m[p]};
    for (int j = 0; j < k; j++) s += {16'b0, act_m[p+j]} * {16'b0, filt_m[j]};
    return s[15:0];
  endfunction

  function automatic bit cfg_ok(int f, int n);
    return f >= 1 && n >= 1 && n <= 16 && f <= 8 && f + n - 1 <= 16;
  endfunction

  task automatic tick();
    int  p, k;
    bit  idle_before, busy_m;
    @(posedge clk); #1;
    if (reset) begin
      in_job = 0; exp_cfg_err = 0; valid = 1;
      last_a = '0; last_w = '0; last_sum = '0;
    end else begin
      exp_cfg_err = 0;
      busy_m = in_job && jc <= fl*np + 1;
      if (in_job && jc <= fl*np) begin
        p = (jc-1) / fl; k = (jc-1) % fl;
        last_a = act_m[p+k]; last_w = filt_m[k]; last_sum = partial(p, k);
      end
      if (in_job && jc >= fl+1 && jc <= fl*np+1 && (jc-1) % fl == 0) begin
        p = (jc-1) / fl - 1;
        psum_m[p] = partial(p, fl);
      end
      if (!busy_m) begin
        if (act_wr_en)  act_m[act_wr_addr]   = act_wr_data;
        if (filt_wr_en) filt_m[filt_wr_addr] = filt_wr_data;
        if (psum_wr_en) psum_m[psum_wr_addr] = psum_wr_data;
      end
      idle_before = !in_job;
      if (in_job) begin
        jc++;
        if (jc > fl*np + 2) in_job = 0;
      end
      if (idle_before && start) begin
        if (cfg_ok(int'(filt_len), int'(num_psum))) begin
          in_job = 1; jc = 1; fl = int'(filt_len); np = int'(num_psum);
        end else exp_cfg_err = 1;
      end
    end
    psum_rd_addr = 4'($urandom_range(0, 15));
  endtask

  always @(negedge clk) if (valid) begin
    bit          en_m;
    int          p, k;
    logic [15:0] ea, ew, es;
    en_m = in_job && jc <= fl*np;
    if (en_m) begin
      p = (jc-1) / fl; k = (jc-1) % fl;
      ea = act_m[p+k]; ew = filt_m[k]; es = partial(p, k);
    end else begin
      ea = last_a; ew = last_w; es = last_sum;
    end
    chk("busy", 32'(busy), 32'(in_job && jc <= fl*np + 1));
    chk("done", 32'(done), 32'(in_job && jc == fl*np + 2));
    chk("mac_en", 32'(mac_en), 32'(en_m));
    chk("cfg_err", 32'(cfg_err), 32'(exp_cfg_err));
    chk("mac_a", 32'(mac_a), 32'(ea));
    chk("mac_w", 32'(mac_w), 32'(ew));
    chk("mac_sum", 32'(mac_sum), 32'(es));
    chk("psum_rd", 32'(psum_rd_data), 32'(psum_m[psum_rd_addr]));
  end

  task automatic wr_act(int a, logic [15:0] d);
    act_wr_en = 1; act_wr_addr = a[3:0]; act_wr_data = d; tick(); act_wr_en = 0;
  endtask
  task automatic wr_filt(int a, logic [15:0] d);
    filt_wr_en = 1; filt_wr_addr = a[2:0]; filt_wr_data = d; tick(); filt_wr_en = 0;
  endtask
  task automatic wr_psum(int a, logic [15:0] d);
    psum_wr_en = 1; psum_wr_addr = a[3:0]; psum_wr_data = d; tick(); psum_wr_en = 0;
  endtask
  task automatic start_job(int f, int n);
    filt_len = f[3:0]; num_psum = n[4:0]; start = 1; tick(); start = 0;
  endtask
  task automatic rd_lit(string name, int a, int exp);
    psum_rd_addr = a[3:0]; #1;
    chk(name, 32'(psum_rd_data), 32'(exp));
    chk({name, "_model"}, 32'(psum_m[a]), 32'(exp));
  endtask
  task automatic wait_idle();
    for (int c = 0; c < 200 && in_job; c++) tick();
    chk("job_timeout", 32'(in_job), 32'(0));
  endtask
  task automatic load_job1();
    for (int i = 0; i < 4; i++) wr_act(i, 16'(i+1));
    for (int i = 0; i < 3; i++) wr_filt(i, 16'd1);
  endtask

  initial begin
    int c, en_cnt;
    reset = 1; act_wr_en = 0; filt_wr_en = 0; psum_wr_en = 0; start = 0;
    act_wr_addr = 0; act_wr_data = 0; filt_wr_addr = 0; filt_wr_data = 0;
    psum_wr_addr = 0; psum_wr_data = 0; psum_rd_addr = 0; filt_len = 0; num_psum = 0;
    tick(); tick();
    reset = 0;
    for (int i = 0; i < 16; i++) wr_act(i, 16'($urandom));
    for (int i = 0; i < 8; i++)  wr_filt(i, 16'($urandom));
    for (int i = 0; i < 16; i++) wr_psum(i, 16'($urandom));

    // 3-tap, 2-output job; done lands in cycle 8
    load_job1(); wr_psum(0, 0); wr_psum(1, 0);
    start_job(3, 2);
    c = 1;
    while (!done && c < 50) begin tick(); c++; end
    chk("done_cycle", 32'(c), 32'd8);
    rd_lit("job1_psum0", 0, 6);
    rd_lit("job1_psum1", 1, 9);
    tick();

    // single tap: every sum comes from the spad
    for (int i = 0; i < 4; i++) begin wr_act(i, 16'(i+1)); wr_psum(i, 16'd10); end
    wr_filt(0, 16'd2);
    start_job(1, 4);
    en_cnt = mac_en ? 1 : 0;
    for (c = 0; c < 20 && in_job; c++) begin tick(); if (mac_en) en_cnt++; end
    chk("fl1_en_cycles", 32'(en_cnt), 32'd4);
    rd_lit("fl1_psum0", 0, 12);
    rd_lit("fl1_psum3", 3, 18);

    // rejected configurations
    start_job(0, 2);
    chk("cfg_err_fl0", 32'(cfg_err), 32'd1);
    chk("cfg_err_fl0_busy", 32'(busy), 32'd0);
    tick();
    start_job(8, 10);
    chk("cfg_err_span", 32'(cfg_err), 32'd1);
    tick();
    rd_lit("cfg_err_psum_kept", 0, 12);

    // truncation
    wr_act(0, 16'h8000); wr_filt(0, 16'd2); wr_psum(0, 16'd0);
    start_job(1, 1);
    wait_idle();
    rd_lit("trunc_psum0", 0, 0);

    // reset 3 cycles into a 3x2 job
    load_job1(); wr_psum(0, 16'd5); wr_psum(1, 16'd7);
    start_job(3, 2); tick(); tick();
    reset = 1; tick(); reset = 0;
    chk("abort_mac_en", 32'(mac_en), 32'd0);
    for (int i = 0; i < 10; i++) begin tick(); chk("abort_no_done", 32'(done), 32'd0); end
    rd_lit("abort_psum1", 1, 7);
    start_job(3, 2);
    wait_idle();
    rd_lit("restart_psum0", 0, 11);

    // start and act writes during RUN are ignored
    wr_psum(0, 0); wr_psum(1, 0);
    start_job(3, 2); tick();
    start = 1; filt_len = 1; num_psum = 1;
    act_wr_en = 1; act_wr_addr = 1; act_wr_data = 16'd99;
    tick();
    start = 0; act_wr_en = 0;
    wait_idle();
    rd_lit("disturb_psum0", 0, 6);
    rd_lit("disturb_psum1", 1, 9);

    // randomized jobs
    for (int j = 0; j < 40; j++) begin
      int f, n, abort_at;
      for (int i = 0; i < 6; i++) begin
        case ($urandom_range(0, 2))
          0: wr_act($urandom_range(0, 15), 16'($urandom));
          1: wr_filt($urandom_range(0, 7), 16'($urandom));
          default: wr_psum($urandom_range(0, 15), 16'($urandom));
        endcase
      end
      if ($urandom_range(0, 4) == 0) begin
        f = $urandom_range(0, 15); n = $urandom_range(0, 31);
      end else begin
        f = $urandom_range(1, 8); n = $urandom_range(1, 17 - f);
      end
      abort_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 12) : -1;
      start_job(f, n);
      for (c = 1; c < 200 && in_job; c++) begin
        if (c == abort_at) reset = 1;
        if ($urandom_range(0, 5) == 0) begin
          start = 1; filt_len = 4'($urandom_range(1, 4)); num_psum = 5'($urandom_range(1, 4));
          act_wr_en = 1; act_wr_addr = 4'($urandom); act_wr_data = 16'($urandom);
          psum_wr_en = 1; psum_wr_addr = 4'($urandom); psum_wr_data = 16'($urandom);
        end
        tick();
        reset = 0; start = 0; act_wr_en = 0; psum_wr_en = 0;
      end
      chk("rand_timeout", 32'(in_job), 32'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
